// File: rtl/elastic_pipe_if.sv
// Valid/ready handshake bundle for elastic_pipe: upstream push side, downstream pop side,
// squash input and occupancy count.
interface elastic_pipe_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready pipeline with bubble collapse and occupancy count.
// Optional squash of all in-flight entries when ELASTIC_PIPE_FLUSH_EN is defined.
module elastic_pipe_stage #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             rdy,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VALUE;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (rdy) begin
      valid_q <= up_valid;
      if (up_valid) data_q <= up_data;
    end
  end
endmodule

module elastic_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic           clk,
  input  logic           reset,
  elastic_pipe_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0]            up_valid;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] up_data;
  logic                        flush_act;
  logic                        push;
  logic                        pop;
  logic [CW-1:0]               count_q;

`ifdef ELASTIC_PIPE_FLUSH_EN
  assign flush_act = bus.flush;
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_act    = 1'b0;
`endif

  // Ready ripples from the output back to stage 0: a stage can load if it is
  // empty or everything ahead of it is moving.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = !valid_q[DEPTH-1] || bus.out_ready;
    rdy[DEPTH-1] = acc;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      acc    = !valid_q[i] || acc;
      rdy[i] = acc;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_valid[i] = bus.in_valid;
      assign up_data[i]  = bus.in_data;
    end else begin : g_body
      assign up_valid[i] = valid_q[i-1];
      assign up_data[i]  = data_q[i-1];
    end

    elastic_pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clr      (flush_act),
      .rdy      (rdy[i]),
      .up_valid (up_valid[i]),
      .up_data  (up_data[i]),
      .valid_q  (valid_q[i]),
      .data_q   (data_q[i])
    );
  end

  assign bus.in_ready  = rdy[0] && !flush_act;
  assign bus.out_valid = valid_q[DEPTH-1] && !flush_act;
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.count     = count_q;

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Counter mirrors popcount(valid_q) without an adder tree across stages.
  always_ff @(posedge clk) begin
    if (!reset || flush_act) begin
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised N-stage valid/ready pipeline register, the handshaked successor of the plain enable-gated flip-flop chain. Each stage carries a valid bit, and empty stages collapse, so the chain absorbs backpressure without stalling upstream while free slots remain. It is used between brisc pipeline sections and memory-side paths that need a fixed minimum latency, full throughput, occupancy visibility and squash on redirect.

## Interface
- `WIDTH`, default `XLEN` (32): data width in bits.
- `DEPTH`, default 3: number of register stages; must be ≥ 1.
- `RESET_VALUE`, default `'0`: value loaded into every data register on reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset == 0` at a rising edge resets all state.
- `in_valid`  in  1  upstream has data.
- `in_ready`  out  1  pipe accepts data this cycle (combinational).
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  last stage holds data.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  last-stage payload.
- `flush`  in  1  squash all in-flight entries (see Configuration).
- `count`  out  $clog2(DEPTH+1)  number of valid stages.

## Operation
- Stage state: `valid_q[i]` and `data_q[i]` for i = 0..DEPTH-1. Stage 0 faces the input; stage DEPTH-1 drives `out_valid` and `out_data`.
- Stage readiness:
  - `rdy[DEPTH-1] = !valid_q[DEPTH-1] || out_ready`.
  - `rdy[i] = !valid_q[i] || rdy[i+1]`.
  - `in_ready = rdy[0]`.
  - This is a combinational chain; no registered ready.
- Stage advance: when `rdy[i]`, stage i loads from stage i-1 (stage 0 loads from the input):
  - `valid_q[i] <= upstream valid`.
  - `data_q[i]` is written only when upstream valid = 1; otherwise it holds.
  - When `!rdy[i]`, the stage holds both valid and data.
- Handshakes:
  - Input handshake: `in_valid && in_ready`.
  - Output handshake: `out_valid && out_ready`.
  - Data is never dropped or duplicated; order is preserved.
  - `in_data` is sampled only on an input handshake.
  - `out_data` is stable while `out_valid && !out_ready`.
  - When `out_valid = 0`, `out_data` holds the last loaded value.
- `count`:
  - +1 on an input handshake only.
  - −1 on an output handshake only.
  - Unchanged when both or neither occur.
  - Always equals popcount(`valid_q`); range 0..DEPTH.
- Full: `count == DEPTH` and `out_ready = 0` gives `in_ready = 0`. With `out_ready = 1` while full, `in_ready = 1`: simultaneous push and pop are allowed.
- Empty: `out_valid = 0`; `in_ready = 1`.
- Reset values:
  - all `valid_q` = 0, `out_valid` = 0, `count` = 0.
  - all `data_q` = `RESET_VALUE`, so `out_data` = `RESET_VALUE`.
  - `in_ready` = 1.
- Reset mid-operation discards all entries. Reset has priority over `flush` and over handshakes.

## Timing
- Minimum latency: DEPTH cycles. An item accepted at edge t appears with `out_valid = 1` after edge t+DEPTH−1, when downstream is ready throughout.
- Throughput: one item per cycle sustained with `out_ready` held at 1.
- Bubble collapse: with `out_ready = 0`, items advance into empty stages each cycle until the pipe is full.
- `count` and `out_valid` are registered-state outputs.
- `in_ready` depends combinationally on `out_ready`. The longest path is `out_ready` → `in_ready` through DEPTH OR gates.

## Configuration
- Macro: `ELASTIC_PIPE_FLUSH_EN`.
- Defined:
  - `flush = 1` at an edge clears all `valid_q` and sets `count` to 0.
  - `data_q` is unchanged.
  - During a flush cycle `in_ready` and `out_valid` are forced to 0, so no handshake occurs and nothing entering or leaving is counted.
  - `reset` overrides `flush`.
- Undefined: the `flush` port exists but is ignored; the flush logic is not synthesised. Integrators tie `flush` to 0.

## Test plan
- Reset: hold `reset = 0` for 2 cycles with random inputs → `out_valid = 0`, `count = 0`, `in_ready = 1`, `out_data = RESET_VALUE`.
- Streaming, DEPTH = 3: push 0x1, 0x2, 0x3, … one per cycle with `out_ready = 1` → 0x1 appears 3 cycles after acceptance, one item per cycle, in order, `count` constant at 3.
- Backpressure fill: `out_ready = 0`, push 0xA, 0xB, 0xC → `count` reaches 3 and `in_ready` drops to 0. A 4th item 0xD is held upstream. Raise `out_ready` → output sequence 0xA, 0xB, 0xC, 0xD with no loss.
- Bubble collapse: push 0x5 at cycle 0 and 0x6 at cycle 2 with `out_ready = 0` → both occupy stages 2 and 1, and `count = 2` by cycle 4.
- Simultaneous push/pop when full, `out_ready = 1` → `in_ready = 1` and `count` stays at 3.
- Flush (macro defined): full pipe, assert `flush` for 1 cycle while `in_valid = 1` → no handshake that cycle, `count = 0` and `out_valid = 0` next cycle, and the next pushed item emerges DEPTH cycles later. With the macro undefined → `flush` has no effect.
